// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one request at a time onto a req/gnt/rvalid SRAM bus,
// with byte-lane enables, load extension and grant/response timeout. Optional macro: MEM_ADDR_CHECK_EN.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] rt_value,
  input  logic [1:0]        mem_type,
  input  logic [2:0]        mem_size,
  input  logic              mem_signed,
  output logic              mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] result,
  output logic              address_error,
  output logic              bus_error,
  output logic              busy
);
  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);

  // Encodings shared with the pipeline's common definitions
  localparam logic [1:0] MEM_NOOP = 2'd0, MEM_LOAD = 2'd1, MEM_STOR = 2'd2;
  localparam logic [2:0] SZ_BYTE = 3'd0, SZ_HALF = 3'd1, SZ_FULL = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {W_BYTE, W_HALF, W_FULL} width_t;

  state_t            state, state_nx;
  width_t            sz, sz_q;
  logic [15:0]       cnt;
  logic              tmo, accept, misal, is_store, store_q, sgn_q;
  logic [OFS-1:0]    off_raw, off, off_q;
  logic [OFS+2:0]    sh_q;
  logic [NB-1:0]     wen_c;
  logic [DATA_W-1:0] wdata_c, ext;
  logic [7:0]        b_v;
  logic [15:0]       h_v;

  always_comb begin
    case (mem_size)
      SZ_BYTE: sz = W_BYTE;
      SZ_HALF: sz = W_HALF;
      SZ_FULL: sz = W_FULL;
      default: sz = W_FULL;
    endcase
  end

  assign accept   = req_valid && (state == IDLE) && (mem_type == MEM_LOAD || mem_type == MEM_STOR);
  assign is_store = (mem_type == MEM_STOR);
  assign off_raw  = address[OFS-1:0];

  always_comb begin
    off = off_raw;
`ifdef MEM_ADDR_CHECK_EN
    misal = (sz == W_HALF && off_raw[0]) || (sz == W_FULL && off_raw != '0);
`else
    // Without checking, wide accesses silently align down to their natural boundary
    if (sz == W_HALF) off[0] = 1'b0;
    else if (sz == W_FULL) off = '0;
    misal = 1'b0;
`endif
  end

  always_comb begin
    wen_c = '0;
    if (is_store) begin
      case (sz)
        W_BYTE:  wen_c = NB'(1) << off;
        W_HALF:  wen_c = NB'(3) << off;
        default: wen_c = '1;
      endcase
    end
  end

  assign wdata_c = rt_value << {off, 3'b000};
  assign sh_q    = {off_q, 3'b000};
  assign b_v     = mem_rdata[sh_q +: 8];
  assign h_v     = mem_rdata[sh_q +: 16];

  always_comb begin
    ext = '0;
    if (!store_q) begin
      case (sz_q)
        W_BYTE:  ext = {{(DATA_W-8){sgn_q & b_v[7]}}, b_v};
        W_HALF:  ext = {{(DATA_W-16){sgn_q & h_v[15]}}, h_v};
        default: ext = mem_rdata;
      endcase
    end
  end

  assign tmo = (cnt == 16'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = misal ? RESP : REQ;
      REQ:  if (mem_gnt) state_nx = WAIT; else if (tmo) state_nx = RESP;
      WAIT: if (mem_rvalid || tmo) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign mem_en     = (state == REQ);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;  cnt <= '0;
      sz_q <= W_BYTE; off_q <= '0; store_q <= 1'b0; sgn_q <= 1'b0;
      mem_addr <= '0; mem_wen <= '0; mem_wdata <= '0;
      result <= '0;   address_error <= 1'b0; bus_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (state == REQ || state == WAIT) cnt <= cnt + 16'd1;
      case (state)
        IDLE: if (accept) begin
          sz_q <= sz; off_q <= off; store_q <= is_store; sgn_q <= mem_signed;
          if (misal) begin
            result <= '0; address_error <= 1'b1; bus_error <= 1'b0;
          end else begin
            mem_addr  <= {address[ADDR_W-1:OFS], {OFS{1'b0}}};
            mem_wen   <= wen_c;
            mem_wdata <= wdata_c;
          end
        end
        REQ: if (!mem_gnt && tmo) begin
          result <= '0; address_error <= 1'b0; bus_error <= 1'b1;
        end
        WAIT: if (mem_rvalid) begin
          result <= ext; address_error <= 1'b0; bus_error <= 1'b0;
        end else if (tmo) begin
          result <= '0; address_error <= 1'b0; bus_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit (TIMEOUT=8) and a 64-bit (TIMEOUT=4) instance driven
// from shared stimulus steered by sel; hand vectors, hand sequences and a randomized model check.
module tb_mem_access_unit;
  localparam logic [1:0] T_NOOP = 2'd0, T_LOAD = 2'd1, T_STOR = 2'd2;
  localparam logic [2:0] S_B = 3'd0, S_H = 3'd1, S_F = 3'd2;

  logic clk = 1'b0, rst = 1'b0, sel = 1'b0;
  logic req_valid = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_signed = 1'b0;
  logic [31:0] address = '0;
  logic [63:0] rt_value = '0, mem_rdata = '0;
  logic [1:0]  mem_type = '0;
  logic [2:0]  mem_size = '0;

  logic rr32, bz32, en32, rv32, ae32, be32, rr64, bz64, en64, rv64, ae64, be64;
  logic [3:0] wen32; logic [7:0] wen64;
  logic [31:0] ma32, wd32, res32, ma64;
  logic [63:0] wd64, res64;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) u32 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr32), .address(address),
    .rt_value(rt_value[31:0]), .mem_type(mem_type), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_en(en32), .mem_wen(wen32), .mem_addr(ma32), .mem_wdata(wd32),
    .mem_gnt(mem_gnt & ~sel), .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata[31:0]),
    .resp_valid(rv32), .result(res32), .address_error(ae32), .bus_error(be32), .busy(bz32));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u64 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr64), .address(address),
    .rt_value(rt_value), .mem_type(mem_type), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_en(en64), .mem_wen(wen64), .mem_addr(ma64), .mem_wdata(wd64),
    .mem_gnt(mem_gnt & sel), .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata),
    .resp_valid(rv64), .result(res64), .address_error(ae64), .bus_error(be64), .busy(bz64));

  logic o_ready, o_busy, o_en, o_resp, o_aerr, o_berr;
  logic [7:0] o_wen; logic [31:0] o_addr; logic [63:0] o_wdata, o_res;
  assign o_ready = sel ? rr64 : rr32;
  assign o_busy  = sel ? bz64 : bz32;
  assign o_en    = sel ? en64 : en32;
  assign o_resp  = sel ? rv64 : rv32;
  assign o_aerr  = sel ? ae64 : ae32;
  assign o_berr  = sel ? be64 : be32;
  assign o_wen   = sel ? wen64 : {4'b0, wen32};
  assign o_addr  = sel ? ma64 : ma32;
  assign o_wdata = sel ? wd64 : {32'b0, wd32};
  assign o_res   = sel ? res64 : {32'b0, res32};

  typedef struct {
    bit sel; bit [31:0] addr; bit [2:0] size; bit [1:0] typ; bit sgn;
    bit [63:0] wdata, rdata; int g, r;
    int lat, en; bit [63:0] res; bit [7:0] wen; bit [31:0] maddr; bit [63:0] mwdata; bit aerr, berr;
  } vec_t;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: lane arithmetic and latency counted from wait lengths
  function automatic vec_t model(input vec_t v);
    int nb, tmo, off, bytes;
    bit mis;
    logic [127:0] full_mask, x;
    nb = v.sel ? 8 : 4;
    tmo = v.sel ? 4 : 8;
    off = int'(v.addr % 32'(nb));
    bytes = (v.size == S_B) ? 1 : (v.size == S_H) ? 2 : nb;
    full_mask = (128'd1 << (8 * nb)) - 128'd1;
`ifdef MEM_ADDR_CHECK_EN
    mis = (bytes > 1) && (off % bytes != 0);
`else
    mis = 1'b0;
    off = off - (off % bytes);
`endif
    v.aerr = 0; v.berr = 0; v.res = 0; v.wen = 0; v.mwdata = 0;
    v.maddr = v.addr - (v.addr % 32'(nb));
    if (mis) begin v.lat = 1; v.en = 0; v.aerr = 1; return v; end
    if (v.typ == T_STOR) v.wen = 8'(((1 << bytes) - 1) << off);
    v.mwdata = 64'((128'(v.wdata) << (8 * off)) & full_mask);
    if (v.g >= tmo) begin v.lat = 1 + tmo; v.en = tmo; v.berr = 1; return v; end
    v.en = v.g + 1;
    if (v.r >= tmo) begin v.lat = 2 + v.g + tmo; v.berr = 1; return v; end
    v.lat = v.g + v.r + 3;
    if (v.typ == T_LOAD) begin
      x = ((128'(v.rdata) & full_mask) >> (8 * off)) & ((128'd1 << (8 * bytes)) - 128'd1);
      if (v.sgn && x[8 * bytes - 1]) x = x - (128'd1 << (8 * bytes));
      v.res = 64'(x & full_mask);
    end
    return v;
  endfunction

  task automatic present(input vec_t v);
    @(negedge clk);
    sel = v.sel; mem_gnt = 0; mem_rvalid = 0; mem_rdata = v.rdata;
    #1;
    for (int w = 0; w < 20 && !o_ready; w++) @(negedge clk);
    chk("ready_before_req", o_ready, 1'b1);
    address = v.addr; mem_size = v.size; mem_type = v.typ; mem_signed = v.sgn; rt_value = v.wdata;
    req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic run(input vec_t v, input string tag);
    int en_cnt, wait_idx, lat, busy_bad, bus_bad;
    bit gnt_now, rv_now;
    logic [103:0] first_bus;
    logic [63:0] res_seen; logic ae_seen, be_seen;
    en_cnt = 0; wait_idx = -1; lat = 0; busy_bad = 0; bus_bad = 0; first_bus = '0;
    res_seen = '0; ae_seen = 0; be_seen = 0;
    present(v);
    for (int k = 1; k <= 40; k++) begin
      if (!o_busy || o_ready) busy_bad++;
      if (o_en) begin
        if (en_cnt == 0) first_bus = {o_wen, o_addr, o_wdata};
        else if (first_bus != {o_wen, o_addr, o_wdata}) bus_bad++;
      end
      if (o_resp) begin
        lat = k; res_seen = o_res; ae_seen = o_aerr; be_seen = o_berr;
        break;
      end
      gnt_now = o_en && (en_cnt == v.g);
      rv_now = (wait_idx >= 0) && (wait_idx == v.r);
      if (wait_idx >= 0) wait_idx++;
      if (gnt_now) wait_idx = 0;
      if (o_en) en_cnt++;
      mem_gnt = gnt_now; mem_rvalid = rv_now;
      @(negedge clk);
    end
    mem_gnt = 0; mem_rvalid = 0;
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".en_cycles"}, en_cnt, v.en);
    chk({tag, ".result"}, res_seen, v.res);
    chk({tag, ".errors"}, {ae_seen, be_seen}, {v.aerr, v.berr});
    chk({tag, ".busy"}, busy_bad, 0);
    if (v.en > 0) begin
      chk({tag, ".bus"}, first_bus, {v.wen, v.maddr, v.mwdata});
      chk({tag, ".bus_stable"}, bus_bad, 0);
    end
    @(negedge clk);
    chk({tag, ".ready_after"}, {o_ready, o_resp}, 2'b10);
  endtask

  vec_t tv[11];
  vec_t rv;
  int bad;

  initial begin
    tv[0]  = '{0, 32'h103, S_B, T_LOAD, 1, 0, 64'h80123456, 0, 0, 3, 1, 64'hFFFFFF80, 0, 32'h100, 0, 0, 0};
    tv[1]  = '{0, 32'h103, S_B, T_LOAD, 0, 0, 64'h80123456, 0, 0, 3, 1, 64'h80, 0, 32'h100, 0, 0, 0};
    tv[2]  = '{1, 32'h206, S_H, T_STOR, 0, 64'hBEEF, 0, 0, 0, 3, 1, 0, 8'hC0, 32'h200, 64'hBEEF000000000000, 0, 0};
`ifdef MEM_ADDR_CHECK_EN
    tv[3]  = '{0, 32'h102, S_F, T_LOAD, 0, 0, 64'hCAFEF00D, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    tv[10] = '{0, 32'h101, S_H, T_STOR, 0, 64'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
`else
    tv[3]  = '{0, 32'h102, S_F, T_LOAD, 0, 0, 64'hCAFEF00D, 0, 0, 3, 1, 64'hCAFEF00D, 0, 32'h100, 0, 0, 0};
    tv[10] = '{0, 32'h101, S_H, T_STOR, 0, 64'h1234, 0, 0, 0, 3, 1, 0, 8'h03, 32'h100, 64'h1234, 0, 0};
`endif
    tv[4]  = '{0, 32'h100, S_B, T_LOAD, 0, 0, 64'hA5, 3, 5, 11, 4, 64'hA5, 0, 32'h100, 0, 0, 0};
    tv[5]  = '{1, 32'h200, S_F, T_LOAD, 0, 0, 64'h1234, 9, 0, 5, 4, 0, 0, 32'h200, 0, 0, 1};
    tv[6]  = '{0, 32'h104, S_H, T_LOAD, 1, 0, 64'h7FFF, 0, 9, 10, 1, 0, 0, 32'h104, 0, 0, 1};
    tv[7]  = '{1, 32'h20A, S_H, T_LOAD, 1, 0, 64'h11112222F00D3333, 0, 0, 3, 1, 64'hFFFFFFFFFFFFF00D, 0, 32'h208, 0, 0, 0};
    tv[8]  = '{0, 32'h101, S_B, T_STOR, 0, 64'h5A, 0, 1, 2, 6, 2, 0, 8'h02, 32'h100, 64'h5A00, 0, 0};
    tv[9]  = '{1, 32'h1F8, S_F, T_STOR, 0, 64'h0123456789ABCDEF, 0, 0, 0, 3, 1, 0, 8'hFF, 32'h1F8, 64'h0123456789ABCDEF, 0, 0};

    #12;
    chk("reset32", {rr32, bz32, en32, wen32, ma32, wd32, rv32, res32, ae32, be32}, {1'b1, 105'd0});
    chk("reset64", {rr64, bz64, en64, wen64, ma64, wd64, rv64, res64, ae64, be64}, {1'b1, 173'd0});
    @(negedge clk); rst = 1;

    foreach (tv[i]) run(tv[i], $sformatf("vec%0d", i));

    // Stray response after a timeout must be dropped
    run(tv[5], "tmo_again");
    sel = 1; mem_rvalid = 1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) mem_rvalid = 0;
      if (o_resp || !o_ready || o_en) bad++;
    end
    chk("stray_rvalid_idle", bad, 0);

    // NOOP is consumed silently
    rv = tv[0]; rv.typ = T_NOOP;
    present(rv);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (o_resp || !o_ready || o_en) bad++;
      @(negedge clk);
    end
    chk("noop_silent", bad, 0);

    // Reset asserted while waiting for the response
    present(tv[0]);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("wait_state", {en32, bz32, rr32}, 3'b010);
    #2 rst = 0;
    #1 chk("reset_in_wait", {rr32, bz32, en32, wen32, ma32, wd32, rv32, res32, ae32, be32}, {1'b1, 105'd0});
    @(negedge clk); rst = 1; mem_rvalid = 1;
    @(negedge clk); mem_rvalid = 0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (rv32 || !rr32) bad++;
      @(negedge clk);
    end
    chk("post_reset_drop", bad, 0);
    run(tv[1], "post_reset");

    for (int i = 0; i < 150; i++) begin
      rv.sel = 1'($urandom);
      rv.addr = $urandom & 32'hFFFF;
      rv.size = 3'($urandom % 3);
      rv.typ = ($urandom % 2) ? T_STOR : T_LOAD;
      rv.sgn = 1'($urandom);
      rv.wdata = {$urandom, $urandom};
      rv.rdata = {$urandom, $urandom};
      rv.g = ($urandom % 8 == 0) ? (rv.sel ? 4 : 8) + int'($urandom % 2) : int'($urandom % 4);
      rv.r = ($urandom % 8 == 0) ? (rv.sel ? 4 : 8) + int'($urandom % 2) : int'($urandom % 4);
      rv = model(rv);
      run(rv, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
